sysid_read_arbiter: RTL

- Shares one read-only, Avalon-MM-style system-ID/config slave between NUM_REQ requesters (HPS bridge, JTAG master, LVDS link supervisor, ...).
- Arbitrates read requests round-robin and drives the slave address for a configurable read latency.
- Captures the slave data and returns it to the winner with an explicit readdatavalid pulse.
- Sits between the interconnect masters and the slave; the slave itself stays purely combinational/unchanged.

---
 rtl/sysid_read_arbiter_pkg.sv | 20 ++
 rtl/sysid_read_arbiter_if.sv | 26 ++
 rtl/sysid_read_arbiter_rr_arbiter.sv | 40 ++++
 rtl/sysid_read_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/sysid_read_arbiter_pkg.sv
// Shared types and helpers for the system-ID read arbiter.
package sysid_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam int LAT_W = 4;

   // Index width for a requester count; never below one bit.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/sysid_read_arbiter_if.sv
// Requester-side and slave-side bus of the system-ID read arbiter.
// slave = the arbiter's view; master = requesters plus the sysid slave.
interface sysid_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 1,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_read;
   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [NUM_REQ-1:0]        req_waitrequest;
   logic [NUM_REQ-1:0]        req_readdatavalid;
   logic [DATA_W-1:0]         req_readdata;
   logic                      slv_read;
   logic [ADDR_W-1:0]         slv_address;
   logic [DATA_W-1:0]         slv_readdata;

   modport slave (
      input  req_read, req_address, slv_readdata,
      output req_waitrequest, req_readdatavalid, req_readdata, slv_read, slv_address
   );

   modport master (
      output req_read, req_address, slv_readdata,
      input  req_waitrequest, req_readdatavalid, req_readdata, slv_read, slv_address
   );
endinterface

// File: rtl/sysid_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after rr_ptr+1, wrapping.
module rr_arbiter
   import sysid_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]             req,
   input  logic [idx_width(NUM_REQ)-1:0]  rr_ptr,
   output logic [NUM_REQ-1:0]             grant,
   output logic [idx_width(NUM_REQ)-1:0]  grant_idx,
   output logic                           any_req
);
   localparam int IDX_W = idx_width(NUM_REQ);

   logic [IDX_W-1:0]   cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_req;

   // Candidate gi is the requester gi+1 places after the pointer.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi + 1);
         assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                               IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
         assign cand_req[gi] = req[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      grant_idx = '0;
      grant     = '0;
      any_req   = |req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_req[k]) grant_idx = cand_idx[k];
      end
      if (any_req) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/sysid_read_arbiter.sv
// Round-robin sharing of a combinational system-ID slave between NUM_REQ requesters,
// with a fixed read latency and an explicit per-requester readdatavalid strobe.
module sysid_read_arbiter
   import sysid_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = 1,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input logic                clock,
   input logic                reset,
   sysid_read_arbiter_if.slave bus
);
   localparam int IDX_W = idx_width(NUM_REQ);

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [IDX_W-1:0]   winner_reg, winner_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   logic               slv_read_reg, slv_read_next;
   logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
   logic [DATA_W-1:0]  rdata_reg, rdata_next;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               any_req;
   logic [NUM_REQ-1:0] waitreq;
   logic [NUM_REQ-1:0] rdv;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (bus.req_read),
      .rr_ptr    (rr_ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= IDX_W'(NUM_REQ - 1);
         winner_reg   <= '0;
         addr_reg     <= '0;
         slv_read_reg <= 1'b0;
         lat_cnt_reg  <= '0;
         rdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         winner_reg   <= winner_next;
         addr_reg     <= addr_next;
         slv_read_reg <= slv_read_next;
         lat_cnt_reg  <= lat_cnt_next;
         rdata_reg    <= rdata_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rr_ptr_next   = rr_ptr_reg;
      winner_next   = winner_reg;
      addr_next     = addr_reg;
      slv_read_next = slv_read_reg;
      lat_cnt_next  = lat_cnt_reg;
      rdata_next    = rdata_reg;
      waitreq       = '1;
      rdv           = '0;

      case (state_reg)
         IDLE: begin
            // Only the winner sees waitrequest low; that is the accept.
            if (!reset) waitreq = ~grant;
            if (any_req) begin
               winner_next   = grant_idx;
               rr_ptr_next   = grant_idx;
               addr_next     = bus.req_address[grant_idx*ADDR_W +: ADDR_W];
               slv_read_next = 1'b1;
               lat_cnt_next  = '0;
               state_next    = ISSUE;
            end
         end
         ISSUE: begin
            lat_cnt_next = lat_cnt_reg + LAT_W'(1);
            if (lat_cnt_reg == LAT_W'(READ_LATENCY)) begin
               rdata_next    = bus.slv_readdata;
               slv_read_next = 1'b0;
               state_next    = RESP;
            end
         end
         RESP: begin
            rdv[winner_reg] = 1'b1;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.req_waitrequest   = waitreq;
   assign bus.req_readdatavalid = rdv;
   assign bus.req_readdata      = rdata_reg;
   assign bus.slv_read          = slv_read_reg;
   assign bus.slv_address       = addr_reg;

   assert property (@(posedge clock) disable iff (reset) $onehot0(rdv));

endmodule
